// File: rtl/comp_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial unsigned comparator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package comp_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cmp_state_t;

    typedef enum logic [1:0] {
        RES_EQ,
        RES_LT,
        RES_GT
    } cmp_res_t;

    // n  : number of DIGIT-wide digits in a WIDTH-bit operand
    // cw : digit counter width; one spare bit so cnt can step past n-1
    typedef struct packed {
        int n;
        int cw;
    } cmp_dims_t;

    function automatic cmp_dims_t cmp_dims(input int width, input int digit);
        cmp_dims_t d;
        d.n  = width / digit;
        d.cw = $clog2(d.n) + 1;
        return d;
    endfunction

endpackage

// File: rtl/comp_digit_lt.sv
// One DIGIT-bit unsigned comparator slice, reused every cycle by the serial scan.
// Latency: purely combinational.
// Backpressure: none; outputs follow the inputs.
//
// Ports:
//   da, db : digit of operand A / B
//   dlt    : da < db
//   deq    : da == db
module comp_digit_lt #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             dlt,
    output logic             deq
);

    assign dlt = (da < db);
    assign deq = (da == db);

endmodule

// File: rtl/comp_unsign_serial.sv
// Digit-serial unsigned three-way comparator (lt/eq/gt), MSB-first, DIGIT bits per cycle.
// Latency: result valid N=WIDTH/DIGIT edges after the accepting edge (early exit: k+1).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake, a and b sampled when both are high
//   a, b                  : WIDTH-bit unsigned operands, bit WIDTH-1 is the MSB
//   out_valid / out_ready : result handshake
//   lt, eq, gt            : one-hot relation of A to B while out_valid, else all 0
//
// Build option: define COMP_SERIAL_EARLY_EXIT_EN to leave RUN on the first
// differing digit. Left undefined, the scan always walks all N digits so the
// latency does not depend on the operand values (constant-time).
//
// WIDTH must be a multiple of DIGIT, and 1 <= DIGIT <= WIDTH.
module comp_unsign_serial
    import comp_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam cmp_dims_t DIMS = cmp_dims(WIDTH, DIGIT);
    localparam int        N    = DIMS.n;
    localparam int        CW   = DIMS.cw;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    cmp_state_t       state;
    cmp_state_t       state_nxt;
    cmp_res_t         res;

    logic [CW-1:0]    cnt;
    logic             decided;
    logic             res_lt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dlt;
    logic             deq;
    logic             first_diff;
    logic             last_digit;
    logic             accept;

    // The digit under inspection is always the top slice; the registers are
    // shifted left after each step so the next digit moves into place.
    assign dig_a = sh_a[WIDTH-1 -: DIGIT];
    assign dig_b = sh_b[WIDTH-1 -: DIGIT];

    comp_digit_lt #(
        .DIGIT (DIGIT)
    ) u_digit (
        .da  (dig_a),
        .db  (dig_b),
        .dlt (dlt),
        .deq (deq)
    );

    // Only the most significant differing digit decides the relation.
    assign first_diff = !decided && !deq;
    assign last_digit = (cnt == LAST_DIGIT);
    assign accept     = (state == IDLE) && in_valid;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake / result outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        res       = RES_EQ;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (last_digit) begin
                    state_nxt = DONE;
                end
`ifdef COMP_SERIAL_EARLY_EXIT_EN
                if (first_diff) begin
                    state_nxt = DONE;
                end
`endif
            end

            DONE: begin
                out_valid = 1'b1;
                if (decided) begin
                    res = res_lt ? RES_LT : RES_GT;
                end else begin
                    res = RES_EQ;
                end
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result lines are gated by out_valid, so they drop to 0 the moment the
    // FSM leaves DONE (including on an asynchronous reset).
    assign lt = out_valid && (res == RES_LT);
    assign eq = out_valid && (res == RES_EQ);
    assign gt = out_valid && (res == RES_GT);

    // ------------------------------------------------------------------
    // Digit counter and decision flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            decided <= 1'b0;
            res_lt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        decided <= 1'b0;
                        res_lt  <= 1'b0;
                    end
                end

                RUN: begin
                    if (first_diff) begin
                        decided <= 1'b1;
                        res_lt  <= dlt;
                    end
                    cnt <= cnt + 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand shift registers: contents are meaningless outside RUN, so
    // they carry no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_a <= a;
            sh_b <= b;
        end else if (state == RUN) begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
        end
    end

endmodule

// File: tb/tb_comp_unsign_serial.sv
// Self-checking bench: three comparators (DIGIT = 1, 4, 32) with directed
// boundary cases on the DIGIT=4 instance and randomized traffic on all three.
module tb_comp_unsign_serial;

    localparam int W  = 32;
    localparam int NI = 3;

`ifdef COMP_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] out_valid;
    logic [NI-1:0] out_ready;
    logic [NI-1:0] lt;
    logic [NI-1:0] eq;
    logic [NI-1:0] gt;
    logic [W-1:0]  a [NI];
    logic [W-1:0]  b [NI];

    int checks   = 0;
    int failures = 0;

    int acc_cnt [NI] = '{default: 0};
    int res_cnt [NI] = '{default: 0};
    int hot_err [NI] = '{default: 0};

    always #5 clk = ~clk;

    function automatic int dig_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 4 : 32;
    endfunction

    function automatic int n_of(input int g);
        return W / dig_of(g);
    endfunction

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : g_dut
        comp_unsign_serial #(
            .WIDTH (W),
            .DIGIT ((gi == 0) ? 1 : (gi == 1) ? 4 : 32)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .a         (a[gi]),
            .b         (b[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .lt        (lt[gi]),
            .eq        (eq[gi]),
            .gt        (gt[gi])
        );
    end

    // Reference relation: {lt, eq, gt}
    function automatic logic [2:0] model_rel(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y)       return 3'b100;
        else if (x == y) return 3'b010;
        else             return 3'b001;
    endfunction

    // Reference latency: index of the most significant differing digit
    function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y, input int g);
        logic [W-1:0] d;
        int  k;
        bit  found;
        d     = x ^ y;
        k     = 0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && d[i]) begin
                found = 1'b1;
                k     = (W - 1 - i) / dig_of(g);
            end
        end
        if (!found) return n_of(g);
        return EARLY ? (k + 1) : n_of(g);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake monitors, sampled mid-cycle where inputs and outputs are settled
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst && in_valid[g] && in_ready[g])   acc_cnt[g]++;
            if (!rst && out_valid[g] && out_ready[g]) res_cnt[g]++;
            if (out_valid[g]) begin
                if ((32'(lt[g]) + 32'(eq[g]) + 32'(gt[g])) != 1) hot_err[g]++;
            end else if (lt[g] || eq[g] || gt[g]) begin
                hot_err[g]++;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int g, input logic [W-1:0] va, input logic [W-1:0] vb, output bit ok);
        int t;
        t = 0;
        in_valid[g] = 1'b1;
        a[g]        = va;
        b[g]        = vb;
        @(negedge clk);
        while (!in_ready[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready[g];
        if (!ok) check($sformatf("g%0d_accept_timeout", g), 32'(in_ready[g]), 1);
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    // Counts rising edges after acceptance until out_valid; returns at a falling edge.
    task automatic wait_out(input int g, output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid[g] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid[g]) check($sformatf("g%0d_result_timeout", g), 32'(out_valid[g]), 1);
    endtask

    function automatic logic [W-1:0] pick_edge();
        case ($urandom_range(0, 2))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run_random(input int g, input int num);
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   rel;
        bit           ok;
        bit           pre;
        int           lat;
        int           s;
        for (int i = 0; i < num; i++) begin
            va = W'($urandom);
            case ($urandom_range(0, 3))
                0: vb = W'($urandom);
                1: vb = va;
                2: vb = va ^ (32'h1 << $urandom_range(0, W - 1));
                default: begin
                    va = pick_edge();
                    vb = pick_edge();
                end
            endcase
            rel = model_rel(va, vb);
            pre = 1'($urandom_range(0, 1));
            out_ready[g] = pre;
            send(g, va, vb, ok);
            if (!ok) return;
            wait_out(g, lat);
            if (!out_valid[g]) begin
                out_ready[g] = 1'b0;
                return;
            end
            check($sformatf("g%0d_rnd_rel", g), 32'({lt[g], eq[g], gt[g]}), 32'(rel));
            check($sformatf("g%0d_rnd_lat", g), lat, model_lat(va, vb, g));
            if (!pre) begin
                s = $urandom_range(0, 3);
                repeat (s) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    check($sformatf("g%0d_rnd_hold", g),
                          32'({out_valid[g], lt[g], eq[g], gt[g]}), 32'({1'b1, rel}));
                end
                @(posedge clk);
                #1;
                out_ready[g] = 1'b1;
            end
            @(posedge clk);
            #1;
            out_ready[g] = 1'b0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        int acc_base [NI];
        int res_base [NI];
        int num      [NI];

        num = '{500, 1500, 2000};
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int g = 0; g < NI; g++) begin
            a[g] = '0;
            b[g] = '0;
        end

        // Reset state of every instance
        #12;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("g%0d_reset_state", g),
                  32'({in_ready[g], out_valid[g], lt[g], eq[g], gt[g]}), 32'(5'b10000));
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: 5 vs 7 with out_ready already high
        out_ready[1] = 1'b1;
        send(1, 32'h0000_0005, 32'h0000_0007, ok);
        wait_out(1, lat);
        check("t1_lat", lat, 8);
        check("t1_rel", 32'({lt[1], eq[1], gt[1]}), 32'(3'b100));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_after_hs", 32'({in_ready[1], out_valid[1], lt[1], eq[1], gt[1]}), 32'(5'b10000));
        @(posedge clk);
        #1;

        // 2: all-ones equal, then zero equal
        send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
        wait_out(1, lat);
        check("t2_ones_lat", lat, 8);
        check("t2_ones_rel", 32'({lt[1], eq[1], gt[1]}), 32'(3'b010));
        @(posedge clk);
        #1;
        send(1, 32'h0, 32'h0, ok);
        wait_out(1, lat);
        check("t2_zero_lat", lat, 8);
        check("t2_zero_rel", 32'({lt[1], eq[1], gt[1]}), 32'(3'b010));
        @(posedge clk);
        #1;

        // 3: MSB digit differs
        send(1, 32'h8000_0000, 32'h7FFF_FFFF, ok);
        wait_out(1, lat);
        check("t3_lat", lat, EARLY ? 1 : 8);
        check("t3_rel", 32'({lt[1], eq[1], gt[1]}), 32'(3'b001));
        @(posedge clk);
        #1;

        // 4: result held under stall, new operands not taken until handshake
        out_ready[1] = 1'b0;
        send(1, 32'h3, 32'h9, ok);
        wait_out(1, lat);
        check("t4_rel", 32'({lt[1], eq[1], gt[1]}), 32'(model_rel(32'h3, 32'h9)));
        @(posedge clk);
        #1;
        in_valid[1] = 1'b1;
        a[1]        = 32'h9;
        b[1]        = 32'h3;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold", 32'({out_valid[1], lt[1], eq[1], gt[1]}), 32'(4'b1100));
            check("t4_no_accept", 32'(in_ready[1]), 0);
            @(posedge clk);
            #1;
        end
        out_ready[1] = 1'b1;
        send(1, 32'h9, 32'h3, ok);
        wait_out(1, lat);
        check("t4_next_lat", lat, 8);
        check("t4_next_rel", 32'({lt[1], eq[1], gt[1]}), 32'(3'b001));
        @(posedge clk);
        #1;

        // 5: asynchronous reset in the middle of RUN
        send(1, 32'hFFFF_0000, 32'hFFFF_0001, ok);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_rst", 32'({in_ready[1], out_valid[1], lt[1], eq[1], gt[1]}), 32'(5'b10000));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_rst", 32'({in_ready[1], out_valid[1], lt[1], eq[1], gt[1]}), 32'(5'b10000));
        @(posedge clk);
        #1;
        send(1, 32'h1, 32'h0, ok);
        wait_out(1, lat);
        check("t5_fresh_lat", lat, 8);
        check("t5_fresh_rel", 32'({lt[1], eq[1], gt[1]}), 32'(3'b001));
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;

        // 6: randomized traffic on all three digit widths in parallel
        for (int g = 0; g < NI; g++) begin
            acc_base[g] = acc_cnt[g];
            res_base[g] = res_cnt[g];
        end
        fork
            run_random(0, num[0]);
            run_random(1, num[1]);
            run_random(2, num[2]);
        join
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("g%0d_accepted", g), acc_cnt[g] - acc_base[g], num[g]);
            check($sformatf("g%0d_results", g), res_cnt[g] - res_base[g], num[g]);
            check($sformatf("g%0d_onehot", g), hot_err[g], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
